s9io_fifo_thr: RTL and testbench
================================

Name: s9io_fifo_thr

Overview:
Parametrised synchronous FIFO with level reporting, threshold-driven interrupt pending, flush and error accounting. It generalises the fixed command/work FIFOs of the S9 board interface (full/empty flags, IRQ threshold, FIFO reset, error counter) to any width, depth and IRQ direction. Instances sit between the AXI register front-end and the UART framers: one per CMD/WORK RX/TX channel.

Parameters:
DATA_WIDTH, 32, word width in bits
DEPTH, 64, number of entries; power of 2, >= 4
IRQ_MODE, 0, 0 = IRQ_MODE_BELOW (TX: pending while level <= thr); 1 = IRQ_MODE_ABOVE (RX: pending while level >= thr and level != 0)
CNT_WIDTH, 16, width of the overflow drop counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous FIFO clear (CTRL_RST_* equivalent)
cnt_clear  in  1  clears ovf_cnt (CTRL_ERR_CNT_CLEAR equivalent)
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request
rd_data  out  DATA_WIDTH  read word, valid when rd_valid
rd_valid  out  1  rd_data valid (one-cycle pulse per honoured read)
full  out  1  level == DEPTH
empty  out  1  level == 0
level  out  $clog2(DEPTH)+1  current occupancy
irq_en  in  1  interrupt enable
irq_thr  in  $clog2(DEPTH)+1  threshold in words
irq_pend  out  1  interrupt pending
ovf  out  1  sticky: write dropped while full
udf  out  1  sticky: read requested while empty
ovf_cnt  out  CNT_WIDTH  saturating count of dropped writes

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset: pointers 0, level 0, empty 1, full 0, rd_valid 0, rd_data 0, irq_pend 0, ovf 0, udf 0, ovf_cnt 0.
- Read honoured iff rd_en && level != 0, with level sampled at the start of the cycle. rd_data and rd_valid are registered, so latency is 1 cycle. rd_data holds its last value when rd_valid = 0.
- Write honoured iff wr_en && (level != DEPTH || read honoured in the same cycle).
- Full with rd_en && wr_en: both are performed and level stays DEPTH.
- Empty with rd_en && wr_en: the write is performed, the read is rejected, udf is set, and level becomes 1.
- Rejected write: data discarded, ovf set, ovf_cnt += 1, saturating at 2^CNT_WIDTH-1.
- Rejected read: udf set, rd_valid 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is a separate up/down counter: +1 write only, -1 read only, unchanged for both or neither.
- full, empty and level are registered and reflect state after the previous edge.
- flush has priority over rd_en/wr_en in the same cycle. It resets pointers and level to 0, sets empty, clears ovf/udf and forces rd_valid 0 next cycle. It does not affect ovf_cnt.
- cnt_clear zeroes ovf_cnt. If cnt_clear coincides with a dropped write, the result is 0 (clear wins).
- irq_pend is registered and evaluated on the current level register:
  - MODE 0: irq_pend <= irq_en && (level <= irq_thr)
  - MODE 1: irq_pend <= irq_en && (level >= irq_thr) && (level != 0)
  - irq_pend is level-sensitive, not sticky; it deasserts one cycle after the condition stops holding.
- irq_thr > DEPTH:
  - MODE 0: always pending.
  - MODE 1: never pending.
- Reset mid-operation: all state returns to reset values on the same edge; stored RAM contents are don't-care.

Decomposition:
- s9io_pkg gains IRQ_MODE_BELOW = 0 and IRQ_MODE_ABOVE = 1, plus a typedef for the status bundle {full, empty, ovf, udf, irq_pend}. These let the register front-end map each channel onto STAT_REG bits.
- Sub-module s9io_sdp_ram: simple dual-port RAM, one write port and one registered read port, parametrised by DATA_WIDTH/DEPTH, inferable as BRAM/LUTRAM.

Test Plan:
- DEPTH=8, write 0x11..0x18, then read 8 -> full=1 after 8 writes; reads return 0x11..0x18 each 1 cycle after rd_en; empty=1, level=0 at end.
- Full FIFO, 3 extra writes -> data dropped, ovf=1, ovf_cnt=3; simultaneous rd+wr while full keeps level=8 and the read returns the oldest word.
- Empty FIFO, rd_en alone -> udf=1, rd_valid=0; rd_en+wr_en 0xAB while empty -> level=1, then a later read returns 0xAB.
- MODE 0, thr=2, irq_en=1: fill to 3 -> irq_pend 0; read to level 2 -> irq_pend=1 one cycle later; irq_en=0 -> irq_pend=0 next cycle.
- MODE 1, thr=4: write 4 words -> irq_pend=1 on the cycle after level=4; flush -> level=0 and irq_pend=0 next cycle; ovf_cnt unchanged.
- Write pointer wrap (20 write/read pairs at DEPTH=8) then rst mid-stream -> data order preserved across the wrap; after rst all outputs match reset values, including ovf_cnt=0.

Source files
------------

// File: rtl/s9io_pkg.sv
// s9io_pkg: shared IRQ mode constants and status bundle for the S9 FIFO channels
package s9io_pkg;
  localparam int IRQ_MODE_BELOW = 0;
  localparam int IRQ_MODE_ABOVE = 1;
  typedef struct packed {
    logic full;
    logic empty;
    logic ovf;
    logic udf;
    logic irq_pend;
  } s9io_stat_t;
endpackage

// File: rtl/s9io_sdp_ram.sv
// s9io_sdp_ram: simple dual-port RAM, one write port and one registered read port
module s9io_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  // read-first: a same-address write lands after the old word is captured
  always_ff @(posedge clk)
    if (rst) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/s9io_fifo_thr.sv
// s9io_fifo_thr: synchronous FIFO with level, threshold IRQ, flush and overflow accounting
module s9io_fifo_thr
  import s9io_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int IRQ_MODE = IRQ_MODE_BELOW,
  parameter int CNT_WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  cnt_clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [LW-1:0]         level,
  input  logic                  irq_en,
  input  logic [LW-1:0]         irq_thr,
  output logic                  irq_pend,
  output logic                  ovf,
  output logic                  udf,
  output logic [CNT_WIDTH-1:0]  ovf_cnt
);
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic rd_ok, wr_ok, drop, irq_d, rd_valid_q, irq_q, ovf_q, udf_q;
  always_comb begin
    rd_ok = !flush && rd_en && level_q != '0;
    wr_ok = !flush && wr_en && (level_q != LW'(DEPTH) || rd_ok);
    drop = !flush && wr_en && !wr_ok;
    level_d = flush ? '0 : level_q + LW'(wr_ok) - LW'(rd_ok);
    irq_d = irq_en && (IRQ_MODE == IRQ_MODE_ABOVE ? (level_q >= irq_thr && level_q != '0)
                                                  : (level_q <= irq_thr));
    cnt_d = cnt_clear ? '0 : (drop && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_ok);
      rd_ptr_q <= rd_ptr_q + AW'(rd_ok);
    end
  always_ff @(posedge clk)
    if (rst) begin
      level_q <= '0;
      rd_valid_q <= 1'b0;
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      level_q <= level_d;
      rd_valid_q <= rd_ok;
      irq_q <= irq_d;
      ovf_q <= !flush && (ovf_q || drop);
      udf_q <= !flush && (udf_q || (rd_en && level_q == '0));
      cnt_q <= cnt_d;
    end
  s9io_sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .rst(rst),
    .we_i(wr_ok),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .re_i(rd_ok),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );
  assign rd_valid = rd_valid_q;
  assign level = level_q;
  assign full = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign irq_pend = irq_q;
  assign ovf = ovf_q;
  assign udf = udf_q;
  assign ovf_cnt = cnt_q;
endmodule

// File: tb/tb_s9io_fifo_thr.sv
// tb_s9io_fifo_thr: directed plan plus random traffic against a queue-based model
module tb_s9io_fifo_thr;
  localparam int DW = 8, DEPTH = 8, CW = 4, LW = 4;
  logic clk = 1'b0;
  logic rst, flush, cnt_clear, wr_en, rd_en, irq_en;
  logic [DW-1:0] wr_data;
  logic [LW-1:0] irq_thr;
  logic [DW-1:0] rd_data0, rd_data1;
  logic rd_valid0, rd_valid1, full0, full1, empty0, empty1, irq0, irq1, ovf0, ovf1, udf0, udf1;
  logic [LW-1:0] level0, level1;
  logic [CW-1:0] cnt0, cnt1;
  logic [7:0] q[$];
  int m_data, m_vld, m_ovf, m_udf, m_cnt, m_irq0, m_irq1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  s9io_fifo_thr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IRQ_MODE(0), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clear(cnt_clear), .wr_en(wr_en),
    .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .full(full0), .empty(empty0), .level(level0), .irq_en(irq_en), .irq_thr(irq_thr),
    .irq_pend(irq0), .ovf(ovf0), .udf(udf0), .ovf_cnt(cnt0));
  s9io_fifo_thr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IRQ_MODE(1), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .cnt_clear(cnt_clear), .wr_en(wr_en),
    .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .full(full1), .empty(empty1), .level(level1), .irq_en(irq_en), .irq_thr(irq_thr),
    .irq_pend(irq1), .ovf(ovf1), .udf(udf1), .ovf_cnt(cnt1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int n = q.size();
    check("level", 32'(level0), n);
    check("full", 32'(full0), n == DEPTH);
    check("empty", 32'(empty0), n == 0);
    check("rd_valid", 32'(rd_valid0), m_vld);
    check("rd_data", 32'(rd_data0), m_data);
    check("ovf", 32'(ovf0), m_ovf);
    check("udf", 32'(udf0), m_udf);
    check("ovf_cnt", 32'(cnt0), m_cnt);
    check("irq_below", 32'(irq0), m_irq0);
    check("irq_above", 32'(irq1), m_irq1);
    check("level_m1", 32'(level1), n);
    check("rd_data_m1", 32'(rd_data1), m_data);
  endtask

  task automatic step(input bit f, input bit cc, input bit we, input logic [7:0] wd, input bit re);
    int lvl = q.size();
    bit rd, wr;
    flush = f; cnt_clear = cc; wr_en = we; wr_data = wd; rd_en = re;
    m_irq0 = int'(irq_en && lvl <= int'(irq_thr));
    m_irq1 = int'(irq_en && lvl >= int'(irq_thr) && lvl != 0);
    if (f) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_vld = 0;
    end else begin
      rd = re && lvl != 0;
      wr = we && (lvl != DEPTH || rd);
      m_vld = rd;
      if (rd) m_data = q.pop_front();
      if (wr) q.push_back(wd);
      if (re && lvl == 0) m_udf = 1;
      if (we && !wr) begin
        m_ovf = 1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end
    if (cc) m_cnt = 0;
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic reset_dut();
    rst = 1; flush = 0; cnt_clear = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    m_data = 0; m_vld = 0; m_ovf = 0; m_udf = 0; m_cnt = 0; m_irq0 = 0; m_irq1 = 0;
    compare_all();
  endtask

  initial begin
    irq_en = 0; irq_thr = '0;
    reset_dut();
    check("rst_empty", 32'(empty0), 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'h11 + i), 0);
    check("plan_full", 32'(full0), 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 8'h00, 1);
      check("plan_order", 32'(rd_data0), 32'(8'h11 + i));
    end
    check("plan_drained", 32'(level0), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'h21 + i), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hEE, 0);
    check("plan_ovf_cnt", 32'(cnt0), 3);
    step(0, 0, 1, 8'hC0, 1);
    check("plan_rdwr_full", 32'(rd_data0), 32'h21);
    check("plan_rdwr_level", 32'(level0), 8);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    check("plan_udf", 32'(udf0), 1);
    step(0, 0, 1, 8'hAB, 1);
    check("plan_empty_rdwr", 32'(level0), 1);
    step(0, 0, 0, 8'h00, 1);
    check("plan_ab", 32'(rd_data0), 32'hAB);
    irq_en = 1; irq_thr = 2;
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(i), 0);
    step(0, 0, 0, 8'h00, 0);
    check("plan_irq_lo_off", 32'(irq0), 0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);
    check("plan_irq_lo_on", 32'(irq0), 1);
    irq_en = 0;
    step(0, 0, 0, 8'h00, 0);
    check("plan_irq_dis", 32'(irq0), 0);
    irq_en = 1; irq_thr = 4;
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(i), 0);
    step(0, 0, 0, 8'h00, 0);
    check("plan_irq_hi_on", 32'(irq1), 1);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    check("plan_irq_hi_off", 32'(irq1), 0);
    check("plan_flush_cnt", 32'(cnt0), 3);
    irq_thr = 9;
    step(0, 0, 0, 8'h00, 0);
    check("plan_thr_big_lo", 32'(irq0), 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 8'(8'h40 + i), 0);
      step(0, 0, 0, 8'h00, 1);
      check("plan_wrap", 32'(rd_data0), 32'(8'h40 + i));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(i), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 8'hFF, 0);
    check("plan_cnt_sat", 32'(cnt0), 15);
    step(0, 1, 1, 8'hFF, 0);
    check("plan_cnt_clr", 32'(cnt0), 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 8'hFF, 0);
    step(0, 0, 1, 8'h55, 1);
    reset_dut();
    check("plan_rst_cnt", 32'(cnt0), 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) irq_thr = LW'($urandom_range(0, 10));
      if ($urandom_range(0, 15) == 0) irq_en = 1'($urandom);
      if ($urandom_range(0, 199) == 0) reset_dut();
      else step($urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
